pulse_dispatch: RTL and testbench

PULSE_DISPATCH -- requirements
Module: pulse_dispatch

---
 rtl/pulse_dispatch_pkg.sv | 10 +
 rtl/cmd_fifo.sv | 51 +++++
 rtl/pulse_dispatch.sv | 90 +++++++++
 tb/tb_pulse_dispatch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_dispatch_pkg.sv
// rtl/pulse_dispatch_pkg.sv - shared FSM state type and default widths for pulse_dispatch
package pulse_dispatch_pkg;
  localparam int PULSE_CMD_WIDTH = 72;
  localparam int ELEM_SEL_WIDTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;
endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - single-clock command FIFO; count is the only full/empty indicator
module cmd_fifo #(
  parameter int WIDTH = pulse_dispatch_pkg::PULSE_CMD_WIDTH,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);
  import pulse_dispatch_pkg::*;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push && (count_q != FULL_COUNT);
    do_pop  = pop && (count_q != '0);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/pulse_dispatch.sv
// rtl/pulse_dispatch.sv - queues pulse commands and issues them one at a time to the
// selected element with a valid/ready handshake.
module pulse_dispatch #(
  parameter int DEPTH = 8,
  parameter int ELEM_SEL_WIDTH = pulse_dispatch_pkg::ELEM_SEL_WIDTH,
  parameter int CMD_WIDTH = pulse_dispatch_pkg::PULSE_CMD_WIDTH,
  localparam int N_ELEM = 2 ** ELEM_SEL_WIDTH,
  localparam int PAY_W = CMD_WIDTH - ELEM_SEL_WIDTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CMD_WIDTH-1:0] cmd_in,
  input  logic                 cstrobe_in,
  output logic [PAY_W-1:0]     elem_cmd,
  output logic [N_ELEM-1:0]    elem_valid,
  input  logic [N_ELEM-1:0]    elem_ready,
  output logic [CW-1:0]        fifo_count,
  output logic                 overflow,
  input  logic                 clear_overflow
);
  import pulse_dispatch_pkg::*;

  logic [CMD_WIDTH-1:0]      head;
  logic [CW-1:0]             count;
  logic                      full, empty, push, pop, drop, handshake;
  logic [ELEM_SEL_WIDTH-1:0] head_sel;
  state_e                    state_q, state_d;
  logic [PAY_W-1:0]          cmd_q, cmd_d;
  logic [N_ELEM-1:0]         valid_q, valid_d;
  logic                      overflow_q, overflow_d;

  cmd_fifo #(
    .WIDTH(CMD_WIDTH),
    .DEPTH(DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(cmd_in),
    .rdata(head),
    .count(count)
  );

  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    // Fullness is judged before this edge's pop, so a same-cycle pop never frees a slot.
    push      = cstrobe_in && !full;
    drop      = cstrobe_in && full;
    handshake = (state_q == ISSUE) && ((valid_q & elem_ready) != '0);
    pop       = !empty && ((state_q == IDLE) || handshake);
    head_sel  = head[CMD_WIDTH-1 -: ELEM_SEL_WIDTH];

    state_d = state_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    if (pop) begin
      state_d           = ISSUE;
      cmd_d             = head[PAY_W-1:0];
      valid_d           = '0;
      valid_d[head_sel] = 1'b1;
    end else if (handshake) begin
      state_d = IDLE;
      valid_d = '0;
    end

    overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign elem_cmd   = cmd_q;
  assign elem_valid = valid_q;
  assign fifo_count = count;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_pulse_dispatch.sv
// tb/tb_pulse_dispatch.sv - scoreboard bench for pulse_dispatch
module tb_pulse_dispatch;
  localparam int CMDW = 72;
  localparam int PW = 70;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CMDW-1:0] cmd_in = '0;
  logic            cstrobe_in = 1'b0;
  logic [PW-1:0]   elem_cmd;
  logic [3:0]      elem_valid;
  logic [3:0]      elem_ready = 4'b0000;
  logic [3:0]      fifo_count;
  logic            overflow;
  logic            clear_overflow = 1'b0;

  int errors = 0;
  int checks = 0;
  int issued = 0;

  logic [CMDW-1:0] exp_q[$];
  logic [CMDW-1:0] mon_e;
  logic [3:0]      mon_v;

  pulse_dispatch dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_in        (cmd_in),
    .cstrobe_in    (cstrobe_in),
    .elem_cmd      (elem_cmd),
    .elem_valid    (elem_valid),
    .elem_ready    (elem_ready),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // Every handshake must match the oldest accepted command.
  always @(negedge clk) begin
    if (!reset && ((elem_valid & elem_ready) != 4'b0000)) begin
      checks++;
      issued++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: elem_valid=%b elem_cmd=%h, scoreboard empty", elem_valid, elem_cmd);
      end else begin
        mon_e = exp_q.pop_front();
        mon_v = 4'b0001 << mon_e[CMDW-1 -: 2];
        if (elem_valid !== mon_v || elem_cmd !== mon_e[PW-1:0]) begin
          errors++;
          $display("FAIL issue_order: got valid=%b cmd=%h, expected valid=%b cmd=%h",
                   elem_valid, elem_cmd, mon_v, mon_e[PW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [PW-1:0] pay, input bit accept);
    cmd_in = {sel, pay};
    cstrobe_in = 1'b1;
    if (accept) exp_q.push_back({sel, pay});
    tick();
    cstrobe_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 200 && !(exp_q.size() == 0 && elem_valid == 4'b0000 && fifo_count == 4'd0)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain: %0d commands still expected, fifo_count=%0d", name, exp_q.size(), fifo_count);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (elem_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", elem_valid); end
    checks++;
    if (elem_cmd !== '0) begin errors++; $display("FAIL reset_cmd: got %h expected 0", elem_cmd); end
    checks++;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_single();
    elem_ready = 4'b0010;
    send(2'd1, 70'hAB, 1'b1);
    checks++;
    if (elem_valid !== 4'b0000) begin errors++; $display("FAIL single_t1_valid: got %b expected 0000", elem_valid); end
    checks++;
    if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_t1_count: got %0d expected 1", fifo_count); end
    tick();
    checks++;
    if (elem_valid !== 4'b0010) begin errors++; $display("FAIL single_t2_valid: got %b expected 0010", elem_valid); end
    checks++;
    if (elem_cmd !== 70'hAB) begin errors++; $display("FAIL single_t2_cmd: got %h expected ab", elem_cmd); end
    tick();
    checks++;
    if (elem_valid !== 4'b0000) begin errors++; $display("FAIL single_t3_valid: got %b expected 0000", elem_valid); end
    checks++;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_t3_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    elem_ready = 4'b1111;
    send(2'd0, 70'h100, 1'b1);
    send(2'd3, 70'h101, 1'b1);
    checks++;
    if (elem_valid !== 4'b0001) begin errors++; $display("FAIL b2b_first: got %b expected 0001", elem_valid); end
    send(2'd2, 70'h102, 1'b1);
    checks++;
    if (elem_valid !== 4'b1000) begin errors++; $display("FAIL b2b_second: got %b expected 1000", elem_valid); end
    tick();
    checks++;
    if (elem_valid !== 4'b0100) begin errors++; $display("FAIL b2b_third: got %b expected 0100", elem_valid); end
    tick();
    checks++;
    if (elem_valid !== 4'b0000) begin errors++; $display("FAIL b2b_idle: got %b expected 0000", elem_valid); end
  endtask

  task automatic test_overflow();
    int base;
    elem_ready = 4'b0000;
    // First command moves into the output register, so nine strobes leave eight queued.
    for (int i = 0; i < 9; i++) send(2'(i % 4), 70'(32'h200 + i), 1'b1);
    checks++;
    if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_full: got %0d expected 8", fifo_count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
    send(2'd1, 70'h2FF, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++;
    if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_after_drop: got %0d expected 8", fifo_count); end
    base = issued;
    elem_ready = 4'b1111;
    drain("ovf");
    checks++;
    if (issued - base !== 9) begin errors++; $display("FAIL ovf_issued: got %0d expected 9", issued - base); end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_hold();
    elem_ready = 4'b1011;
    send(2'd2, 70'h300, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) send(2'd0, 70'h301, 1'b1);
      else if (i == 1) send(2'd3, 70'h302, 1'b1);
      else tick();
      checks++;
      if (elem_valid !== 4'b0100 || elem_cmd !== 70'h300) begin
        errors++;
        $display("FAIL hold_stable_%0d: got valid=%b cmd=%h expected valid=0100 cmd=300", i, elem_valid, elem_cmd);
      end
    end
    checks++;
    if (fifo_count !== 4'd2) begin errors++; $display("FAIL hold_count: got %0d expected 2", fifo_count); end
    elem_ready = 4'b1111;
    drain("hold");
  endtask

  task automatic test_full_handshake();
    elem_ready = 4'b0000;
    for (int i = 0; i < 9; i++) send(2'(3 - (i % 4)), 70'(32'h400 + i), 1'b1);
    elem_ready = 4'b1111;
    clear_overflow = 1'b1;
    send(2'd3, 70'h4FF, 1'b0);
    clear_overflow = 1'b0;
    elem_ready = 4'b0000;
    checks++;
    if (fifo_count !== 4'd7) begin errors++; $display("FAIL full_hs_count: got %0d expected 7", fifo_count); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_hs_overflow: got %b expected 1", overflow); end
    elem_ready = 4'b1111;
    drain("full_hs");
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_hs_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid();
    elem_ready = 4'b0000;
    for (int i = 0; i < 4; i++) send(2'(i), 70'(32'h500 + i), 1'b1);
    checks++;
    if (fifo_count !== 4'd3) begin errors++; $display("FAIL rst_mid_count_before: got %0d expected 3", fifo_count); end
    checks++;
    if (elem_valid !== 4'b0001) begin errors++; $display("FAIL rst_mid_valid_before: got %b expected 0001", elem_valid); end
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (elem_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0000", elem_valid); end
    checks++;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", fifo_count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b expected 0", overflow); end
    tick();
    reset = 1'b0;
    elem_ready = 4'b0010;
    send(2'd1, 70'h555, 1'b1);
    checks++;
    if (elem_valid !== 4'b0000) begin errors++; $display("FAIL rst_post_t1: got %b expected 0000", elem_valid); end
    tick();
    checks++;
    if (elem_valid !== 4'b0010 || elem_cmd !== 70'h555) begin
      errors++;
      $display("FAIL rst_post_t2: got valid=%b cmd=%h expected valid=0010 cmd=555", elem_valid, elem_cmd);
    end
    drain("rst_post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_single();
    test_back_to_back();
    test_overflow();
    test_hold();
    test_full_handshake();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
